// File: rtl/mdu_div_seq_pkg.sv
// Shared constants and types for the multi-cycle divide sequencer.
package mdu_div_seq_pkg;

  localparam int DivWidth = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // MIPS SPECIAL funct codes; execute uses them to choose signed_i.
  localparam logic [5:0] DivOp  = 6'b011010;
  localparam logic [5:0] DivuOp = 6'b011011;

  function automatic logic [DivWidth-1:0] neg_if(input logic neg, input logic [DivWidth-1:0] v);
    return neg ? (~v + DivWidth'(1)) : v;
  endfunction

endpackage

// File: rtl/mdu_div_seq_if.sv
// Request/response bundle between execute and the divide sequencer.
interface mdu_div_seq_if
  import mdu_div_seq_pkg::*;
#(parameter int WIDTH = DivWidth);

  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/mdu_div_seq.sv
// 32-step radix-2 restoring divider with divide-by-zero, annul and pipeline stall handling.
module mdu_div_seq
  import mdu_div_seq_pkg::*;
#(parameter int WIDTH = DivWidth) (
  input logic         clk,
  input logic         rst,
  mdu_div_seq_if.slave div_bus
);

  localparam int CntW = $clog2(WIDTH) + 1;

  div_state_e         state, state_nxt;
  logic [CntW-1:0]    cnt, cnt_nxt;
  logic [2*WIDTH:0]   work, work_nxt;
  logic [WIDTH-1:0]   divisor, divisor_nxt;
  logic               neg_quot, neg_quot_nxt;
  logic               neg_rem, neg_rem_nxt;
  logic [2*WIDTH-1:0] result, result_nxt;
  logic               ready, ready_nxt;

  logic [WIDTH-1:0]   abs1, abs2, quot, rem;
  logic [WIDTH:0]     trial;
  logic               fits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DivFree;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result   <= '0;
      ready    <= DivResultNotReady;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      work     <= work_nxt;
      divisor  <= divisor_nxt;
      neg_quot <= neg_quot_nxt;
      neg_rem  <= neg_rem_nxt;
      result   <= result_nxt;
      ready    <= ready_nxt;
    end
  end

  // Bit 2*WIDTH of work is always zero here; including it keeps the compare exact after the shift.
  always_comb begin
    abs1  = neg_if(div_bus.signed_i & div_bus.opdata1_i[WIDTH-1], div_bus.opdata1_i);
    abs2  = neg_if(div_bus.signed_i & div_bus.opdata2_i[WIDTH-1], div_bus.opdata2_i);
    fits  = work[2*WIDTH:WIDTH-1] >= {2'b00, divisor};
    trial = work[2*WIDTH-1:WIDTH-1] - {1'b0, divisor};
    quot  = neg_if(neg_quot, work[WIDTH-1:0]);
    rem   = neg_if(neg_rem, work[2*WIDTH-1:WIDTH]);
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    work_nxt     = work;
    divisor_nxt  = divisor;
    neg_quot_nxt = neg_quot;
    neg_rem_nxt  = neg_rem;
    result_nxt   = result;
    ready_nxt    = ready;

    case (state)
      DivFree: begin
        if (div_bus.start_i == DivStart && !div_bus.annul_i) begin
          if (div_bus.opdata2_i == '0) begin
            state_nxt = DivByZero;
          end else begin
            state_nxt    = DivOn;
            cnt_nxt      = '0;
            work_nxt     = {{(WIDTH+1){1'b0}}, abs1};
            divisor_nxt  = abs2;
            neg_rem_nxt  = div_bus.signed_i & div_bus.opdata1_i[WIDTH-1];
            neg_quot_nxt = div_bus.signed_i & (div_bus.opdata1_i[WIDTH-1] ^ div_bus.opdata2_i[WIDTH-1]);
          end
        end
      end

      DivByZero: begin
        result_nxt = '0;
        if (div_bus.annul_i) begin
          state_nxt = DivFree;
          ready_nxt = DivResultNotReady;
        end else begin
          state_nxt = DivEnd;
          ready_nxt = DivResultReady;
        end
      end

      DivOn: begin
        if (div_bus.annul_i) begin
          state_nxt  = DivFree;
          ready_nxt  = DivResultNotReady;
          result_nxt = '0;
        end else if (cnt != CntW'(WIDTH)) begin
          work_nxt = fits ? {trial, work[WIDTH-2:0], 1'b1} : {work[2*WIDTH-1:0], 1'b0};
          cnt_nxt  = cnt + CntW'(1);
        end else begin
          state_nxt  = DivEnd;
          ready_nxt  = DivResultReady;
          result_nxt = {rem, quot};
        end
      end

      DivEnd: begin
        if (div_bus.start_i == DivStop) begin
          state_nxt  = DivFree;
          ready_nxt  = DivResultNotReady;
          result_nxt = '0;
        end
      end

      default: state_nxt = DivFree;
    endcase
  end

  assign div_bus.result_o   = result;
  assign div_bus.ready_o    = ready;
  assign div_bus.stallreq_o = div_bus.start_i & ~ready & ~div_bus.annul_i;

endmodule

// File: tb/tb_mdu_div_seq.sv
// Scoreboard bench for mdu_div_seq: random DIV/DIVU traffic against a plain-arithmetic reference.
module tb_mdu_div_seq;
  import mdu_div_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_div_seq_if #(.WIDTH(32)) bus ();

  mdu_div_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  logic        prev_ready = 1'b0;

  // Truncating division computed in 64 bits so 0x80000000 / -1 wraps instead of trapping.
  function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Every rising ready_o consumes one expected result.
  always @(negedge clk) begin
    if (bus.ready_o && !prev_ready) begin
      if (exp_q.size() == 0)
        checkOutput("spurious_ready", {63'd0, bus.ready_o}, 64'd0);
      else
        checkOutput("result", bus.result_o, exp_q.pop_front());
    end
    prev_ready <= bus.ready_o;
  end

  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int waited, stalls, exp_wait;
    exp_wait = (b == 32'd0) ? 2 : 34;
    @(posedge clk); #1;
    bus.start_i   = DivStart;
    bus.signed_i  = sgn;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    exp_q.push_back(refDiv(sgn, a, b));
    waited = 0;
    stalls = 0;
    @(negedge clk);
    while (!bus.ready_o && waited < 100) begin
      if (bus.stallreq_o) stalls++;
      waited++;
      @(posedge clk); #1;
      bus.opdata1_i = $urandom;
      bus.opdata2_i = $urandom;
      bus.signed_i  = ~sgn;
      @(negedge clk);
    end
    checkOutput("latency", 64'(waited), 64'(exp_wait));
    checkOutput("stall_cycles", 64'(stalls), 64'(exp_wait));
    if (!bus.ready_o) begin
      if (exp_q.size() != 0) void'(exp_q.pop_back());
      bus.start_i = DivStop;
      repeat (2) @(posedge clk);
    end else begin
      checkOutput("stall_at_ready", {63'd0, bus.stallreq_o}, 64'd0);
      @(negedge clk);
      checkOutput("hold_ready", {63'd0, bus.ready_o}, 64'd1);
      checkOutput("hold_result", bus.result_o, refDiv(sgn, a, b));
      @(posedge clk); #1;
      bus.start_i = DivStop;
      @(negedge clk);
      checkOutput("ready_before_release", {63'd0, bus.ready_o}, 64'd1);
      @(negedge clk);
      checkOutput("ready_after_release", {63'd0, bus.ready_o}, 64'd0);
      checkOutput("result_after_release", bus.result_o, 64'd0);
    end
  endtask

  initial begin
    int waited;
    logic        sgn;
    logic [31:0] a, b;

    rst           = 1'b0;
    bus.start_i   = DivStop;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.annul_i   = 1'b0;

    #12;
    checkOutput("reset_ready", {63'd0, bus.ready_o}, 64'd0);
    checkOutput("reset_result", bus.result_o, 64'd0);
    checkOutput("reset_stall_idle", {63'd0, bus.stallreq_o}, 64'd0);
    bus.start_i = DivStart;
    #1;
    checkOutput("reset_stall_req", {63'd0, bus.stallreq_o}, 64'd1);
    bus.start_i = DivStop;
    #5 rst = 1'b1;

    $display("[TB] directed operations");
    applyStimulus(1'b0, 32'd100, 32'd7);
    applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2);
    applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE);
    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF);
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1);
    applyStimulus(1'b0, 32'd5, 32'd0);

    $display("[TB] annul at E10");
    @(posedge clk); #1;
    bus.start_i   = DivStart;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd9;
    repeat (10) @(posedge clk);
    #1 bus.annul_i = 1'b1;
    @(negedge clk);
    checkOutput("stall_during_annul", {63'd0, bus.stallreq_o}, 64'd0);
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    bus.start_i = DivStop;
    repeat (40) @(negedge clk);
    checkOutput("annul_no_ready", {63'd0, bus.ready_o}, 64'd0);
    applyStimulus(1'b0, 32'd9, 32'd3);

    $display("[TB] reset at E20");
    @(posedge clk); #1;
    bus.start_i   = DivStart;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    repeat (20) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkOutput("midop_reset_ready", {63'd0, bus.ready_o}, 64'd0);
    checkOutput("midop_reset_result", bus.result_o, 64'd0);
    checkOutput("midop_reset_stall", {63'd0, bus.stallreq_o}, 64'd1);
    bus.start_i = DivStop;
    @(posedge clk); #2 rst = 1'b1;
    applyStimulus(1'b0, 32'd100, 32'd7);

    $display("[TB] reset while result held");
    @(posedge clk); #1;
    bus.start_i   = DivStart;
    bus.signed_i  = 1'b1;
    bus.opdata1_i = 32'hFFFFFFD3;
    bus.opdata2_i = 32'd4;
    exp_q.push_back(refDiv(1'b1, 32'hFFFFFFD3, 32'd4));
    waited = 0;
    @(negedge clk);
    while (!bus.ready_o && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    checkOutput("held_latency", 64'(waited), 64'd34);
    if (exp_q.size() != 0 && !bus.ready_o) void'(exp_q.pop_back());
    #2 rst = 1'b0;
    #1;
    checkOutput("held_reset_ready", {63'd0, bus.ready_o}, 64'd0);
    checkOutput("held_reset_result", bus.result_o, 64'd0);
    bus.start_i = DivStop;
    #3 rst = 1'b1;

    $display("[TB] random operations");
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 15);
        3: a = 32'h80000000;
        4: b = b >> $urandom_range(8, 28);
        default: ;
      endcase
      applyStimulus(sgn, a, b);
    end

    repeat (4) @(negedge clk);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
